// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch and load/store.
// Issues one access per idle cycle, sequences fixed-latency reads and returns data to the owner.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned STRK_W = 4;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STRK_W-1:0]   streak_q;
  logic                owner_fetch_q;
  logic                discard_q;
  logic                if_rv_q;
  logic                d_rv_q;
  logic                fetch_ok;
  logic                force_fetch;
  logic                capture;

  assign fetch_ok    = if_req & ~if_flush;
  assign force_fetch = (streak_q == STRK_W'(MAX_D_STREAK)) & fetch_ok;
  assign capture     = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
  assign busy        = (state_q == S_WAIT);
  assign if_rvalid   = if_rv_q & ~if_flush;
  assign d_rvalid    = d_rv_q;

  // Next-state, grant and memory-strobe decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (d_req && !force_fetch) begin
          d_gnt    = 1'b1;
          mem_en   = 1'b1;
          mem_we   = d_we;
          mem_addr = d_addr;
          if (d_we) begin
            mem_wdata = d_wdata;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(MEM_LAT);
          end
        end else if (fetch_ok) begin
          if_gnt   = 1'b1;
          mem_en   = 1'b1;
          mem_addr = if_addr;
          state_d  = S_WAIT;
          cnt_d    = CNT_W'(MEM_LAT);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Owner tracking, flush discard, response capture and starvation streak
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_fetch_q <= 1'b0;
      discard_q     <= 1'b0;
      if_rv_q       <= 1'b0;
      d_rv_q        <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      streak_q      <= '0;
    end else begin
      if (if_gnt) begin
        owner_fetch_q <= 1'b1;
        discard_q     <= 1'b0;
      end else if (d_gnt && !d_we) begin
        owner_fetch_q <= 1'b0;
        discard_q     <= 1'b0;
      end else if ((state_q == S_WAIT) && owner_fetch_q && if_flush) begin
        discard_q <= 1'b1;
      end
      if_rv_q <= capture & owner_fetch_q & ~discard_q & ~if_flush;
      d_rv_q  <= capture & ~owner_fetch_q;
      if (capture && owner_fetch_q)  if_rdata <= mem_rdata;
      if (capture && !owner_fetch_q) d_rdata  <= mem_rdata;
      if (if_gnt || !if_req) begin
        streak_q <= '0;
      end else if (d_gnt && (streak_q < STRK_W'(MAX_D_STREAK))) begin
        streak_q <= streak_q + STRK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared each cycle against a cycle-numbered transaction model and a memory model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // memory seen by the DUT (environment) and the reference copy used for expectations
  logic [DW-1:0] env_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            rd_due = -1;
  logic [DW-1:0] rd_val;

  // reference model: the port is free from cycle m_free_at; one read response may be pending
  int            m_free_at = 0;
  int            m_streak  = 0;
  bit            p_valid   = 0;
  int            p_rv, p_issue;
  bit            p_fetch, p_disc;
  logic [DW-1:0] p_data;
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_d_rdata  = '0;
  bit            last_ig, last_dg;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'd0, if_gnt, d_gnt}, 32'd0);
    chk({tag, "_mem_en_we"}, {30'd0, mem_en, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_busy_rv"}, {29'd0, busy, if_rvalid, d_rvalid}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // one clock cycle: inputs already applied at the preceding negedge
  task automatic tick();
    bit idle, fok, force_f, e_ig, e_dg, e_irv, e_drv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    mem_rdata = (rd_due == cyc) ? rd_val : DW'($urandom);
    #1;
    e_irv = 0;
    e_drv = 0;
    if (p_valid && p_rv == cyc) begin
      if (p_fetch) m_if_rdata = p_data; else m_d_rdata = p_data;
      e_irv   = p_fetch && !p_disc && !if_flush;
      e_drv   = !p_fetch;
      p_valid = 0;
    end
    idle    = (cyc >= m_free_at);
    fok     = if_req && !if_flush;
    force_f = (m_streak == MAXS) && fok;
    e_dg    = idle && d_req && !force_f;
    e_ig    = idle && fok && !e_dg;
    e_addr  = e_dg ? d_addr : (e_ig ? if_addr : '0);
    e_wdata = (e_dg && d_we) ? d_wdata : '0;
    chk("if_gnt", 32'(if_gnt), 32'(e_ig));
    chk("d_gnt", 32'(d_gnt), 32'(e_dg));
    chk("mem_en", 32'(mem_en), 32'(e_ig || e_dg));
    chk("mem_we", 32'(mem_we), 32'(e_dg && d_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("busy", 32'(busy), 32'(!idle));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_irv));
    chk("d_rvalid", 32'(d_rvalid), 32'(e_drv));
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    // model state update
    if (p_valid && p_fetch && if_flush && cyc > p_issue) p_disc = 1;
    if ((e_dg && !d_we) || e_ig) begin
      p_valid   = 1;
      p_issue   = cyc;
      p_rv      = cyc + LAT + 1;
      p_fetch   = e_ig;
      p_disc    = 0;
      p_data    = ref_mem.exists(e_addr) ? ref_mem[e_addr] : dflt(e_addr);
      m_free_at = cyc + LAT + 1;
    end
    if (e_dg && d_we) ref_mem[d_addr] = d_wdata;
    if (e_ig || !if_req) m_streak = 0;
    else if (e_dg && m_streak < MAXS) m_streak++;
    last_ig = e_ig;
    last_dg = e_dg;
    // environment memory reacts to what the DUT actually drove
    if (mem_en && !mem_we) begin
      rd_due = cyc + LAT;
      rd_val = env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
    end
    if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_flush = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic model_reset();
    m_free_at  = 0;
    m_streak   = 0;
    p_valid    = 0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    rd_due     = -1;
  endtask

  bit ih, dh;

  initial begin
    idle_inputs();
    mem_rdata = '0;
    rst = 1;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 0;
    cyc = 0;
    env_mem[32'h40] = 32'h00500093;
    ref_mem[32'h40] = 32'h00500093;
    tick();

    // single fetch
    if_req = 1; if_addr = 32'h40;
    tick();
    if_req = 0;
    repeat (4) tick();
    chk("fetch_word", if_rdata, 32'h00500093);

    // contention: data read wins, fetch follows once the port frees
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    d_req = 0;
    repeat (LAT) tick();
    tick();
    if_req = 0;
    repeat (4) tick();

    // starvation guard: held writes with a pending fetch
    if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 1; d_addr = 32'h10;
    for (int i = 0; i < 5 + LAT; i++) begin
      d_wdata = DW'($urandom);
      tick();
      if (last_ig) if_req = 0;
    end
    if_req = 0;
    repeat (4) begin d_wdata = DW'($urandom); tick(); end
    idle_inputs();
    repeat (2) tick();

    // flush during WAIT, then a fetch issued in the slot where rvalid would have been
    if_req = 1; if_addr = 32'h48;
    tick();
    if_req = 0; if_flush = 1;
    tick();
    if_flush = 0;
    tick();
    if_req = 1; if_addr = 32'h4C;
    tick();
    if_req = 0;
    repeat (4) tick();

    // write then read back
    d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'hDEADBEEF;
    tick();
    d_we = 0;
    tick();
    idle_inputs();
    repeat (4) tick();
    chk("wr_rd_data", d_rdata, 32'hDEADBEEF);

    // reset in the middle of a fetch WAIT
    if_req = 1; if_addr = 32'h100;
    tick();
    if_req = 0;
    rst = 1;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    @(negedge clk);
    cyc++;
    rst = 0;
    repeat (5) tick();

    // random traffic with hold-until-grant requesters
    ih = 0; dh = 0;
    for (int i = 0; i < 600; i++) begin
      if (ih && !last_ig && ($urandom_range(7) != 0)) begin
        if_req = 1;
      end else begin
        ih = ($urandom_range(1) == 1);
        if_req = ih;
        if_addr = 32'h40 + 32'($urandom_range(15)) * 4;
      end
      if (dh && !last_dg && ($urandom_range(7) != 0)) begin
        d_req = 1;
      end else begin
        dh = ($urandom_range(1) == 1);
        d_req = dh;
        d_we = ($urandom_range(2) == 0);
        d_addr = 32'h300 + 32'($urandom_range(3)) * 4;
        d_wdata = DW'($urandom);
      end
      if_flush = ($urandom_range(7) == 0);
      tick();
    end
    idle_inputs();
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous unified memory between the CPU's instruction-fetch path and its load/store path.
- Sits between the PC/fetch logic and load/store unit on one side, and the memory macro on the other.
- Arbitrates requests, sequences fixed-latency reads, and returns read data to the owner.
- Provides a fetch-flush input so a taken branch/jump can discard an in-flight fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- DATA_W, 32, data word width.
- MEM_LAT, 1, cycles from mem_en (read) to valid mem_rdata; legal 1..4.
- MAX_D_STREAK, 4, max consecutive data grants while if_req is pending before fetch is forced; legal 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  discard any outstanding fetch response.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; d_rdata valid (reads only).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read strobe.
- busy  out  1  high while a read is outstanding.

Behaviour:
- Reset: async clear; state IDLE; streak counter 0; all outputs 0, including if_rdata and d_rdata.
- A reset mid-transaction drops the transaction; no rvalid is ever produced for it.
- FSM states: IDLE, WAIT.
- Issue happens only in IDLE. If_gnt, d_gnt, mem_en, mem_we, mem_addr and mem_wdata are combinational from the requests and the current state.
- At most one grant per cycle.
- Priority: data wins over fetch, unless streak == MAX_D_STREAK and if_req = 1; then fetch wins.
- Streak counter:
  - +1 on each d_gnt while if_req = 1 (saturates at MAX_D_STREAK).
  - Cleared on if_gnt, or on any cycle with if_req = 0.
- Write grant (d_we = 1): mem_en = mem_we = 1 that cycle. The FSM stays in IDLE and no rvalid is produced. Back-to-back writes are possible every cycle.
- Read grant at cycle T: mem_en = 1, mem_we = 0. Go to WAIT and latch the owner (fetch/data) and a counter = MEM_LAT.
- WAIT: the counter decrements each cycle; no grants are issued; busy = 1.
- At cycle T+MEM_LAT (counter reaches 1 → 0):
  - Capture mem_rdata into the owner's rdata register.
  - Return to IDLE.
  - Owner's rvalid = 1 in cycle T+MEM_LAT+1 for exactly one cycle.
- Read-to-read issue spacing is MEM_LAT+1 cycles. A new issue may occur in the same cycle rvalid of the previous read is high.
- rdata registers hold their last value until the next capture for that owner.
- Flush, if_flush = 1:
  - In any cycle while a fetch read is in WAIT, or in its issue cycle: the response is marked discarded. The data is still captured but if_rvalid is suppressed. The FSM timing is unchanged.
  - In the cycle if_rvalid would assert: if_rvalid is forced to 0.
  - In IDLE: blocks if_gnt that cycle.
  - Flush has no effect on data transactions.
- Requester holding req while not granted: no side effects. Dropping req before gnt is legal and cancels the request.
- When neither req is granted, mem_en = mem_we = 0; mem_addr and mem_wdata = 0.

Test Plan:
- Reset/idle: assert rst mid-WAIT (MEM_LAT=2, fetch read of 0x100 issued) → all outputs 0 immediately; no if_rvalid after release.
- Single fetch: MEM_LAT=2, if_req addr 0x40 at T, mem_rdata=0x00500093 at T+2 → if_gnt at T; if_rvalid=1 with if_rdata=0x00500093 at T+3 only; next grant possible at T+3.
- Contention: if_req and d_req (read 0x200) both high at T → d_gnt at T, if_gnt at T+MEM_LAT+1; d_rvalid precedes if_rvalid.
- Starvation guard: MAX_D_STREAK=4, d_req writes held continuously with if_req high → 4 consecutive d_gnt cycles, then if_gnt on the 5th cycle, then the data streak resumes.
- Flush: fetch read issued at T, if_flush pulsed at T+1 (MEM_LAT=2) → if_rvalid stays 0; if_rdata updates silently; a subsequent fetch at T+3 returns normally.
- Write then read: d_we=1 addr 0x300 wdata 0xDEADBEEF at T, then d_req read 0x300 at T+1 → mem_we=1 at T only; d_gnt at T and T+1; d_rvalid at T+1+MEM_LAT+1 with memory-model data 0xDEADBEEF.
